const_mapper: RTL
=================

# const_mapper

Constellation mapper for the uplink NB-IoT PHY. Collects the serial scrambled bit stream, groups bits per modulation order (π/2-BPSK, QPSK, 16-QAM), and drives the two address ports of the constellation constant ROM: port 1 for I and port 2 for Q. It registers the returned I/Q constants as one complex symbol per group under a valid/ready handshake to the next stage (resource mapper).

## Interface
- DATA_WIDTH, 16: width of each ROM constant and of o_sym_i/o_sym_q.
- ADDR_WIDTH, 3: ROM address width; the block requires 3.
- NSYM_WIDTH, 12: width of the symbol-count input.
- i_clk  in  1  clock; the only clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  one-cycle pulse; latches i_mod and i_num_sym and begins a block.
- i_mod  in  2  00 BPSK, 01 QPSK, 10 16-QAM, 11 reserved.
- i_num_sym  in  NSYM_WIDTH  symbols in the block; 0 means no symbols.
- i_bit  in  1  scrambled bit.
- i_bit_valid  in  1  i_bit is present.
- o_bit_ready  out  1  bit accepted when i_bit_valid and o_bit_ready are both high.
- o_rom_addr_1  out  ADDR_WIDTH  I address; combinational.
- o_rom_addr_2  out  ADDR_WIDTH  Q address; combinational.
- i_rom_data_1  in  DATA_WIDTH  I constant; combinational return.
- i_rom_data_2  in  DATA_WIDTH  Q constant; combinational return.
- o_sym_i  out  DATA_WIDTH  symbol I.
- o_sym_q  out  DATA_WIDTH  symbol Q.
- o_sym_valid  out  1  symbol present; held until i_sym_ready.
- i_sym_ready  in  1  downstream accepts.
- o_done  out  1  one-cycle pulse when the last symbol is accepted downstream.
- o_err  out  1  sticky; set when i_start arrives with i_mod = 11. Cleared by reset or by a valid i_start.

## Operation
- ROM layout (fixed):
  - 0: +1/√2
  - 1: −1/√2
  - 2: +1/√10
  - 3: −1/√10
  - 4: +3/√10
  - 5: −3/√10
  - 6–7: unused
- Qm, the bits per symbol: BPSK 1, QPSK 2, 16-QAM 4.
- Bits are ordered b0 first.
- FSM states:
  - IDLE: o_bit_ready = 0. On i_start with a valid i_mod and i_num_sym ≠ 0, go to RUN. With i_num_sym = 0, pulse o_done on the next cycle and stay in IDLE. With i_mod = 11, set o_err and stay in IDLE.
  - RUN: shift bits into the collector; the bit counter counts 0..Qm−1. When the Qm-th bit is accepted, drive ROM addresses from the collected bits plus the incoming bit, load the output register, clear the bit counter and increment the symbol counter. After the last symbol is loaded, go to DRAIN.
  - DRAIN: o_bit_ready = 0. When the output is accepted, pulse o_done and go to IDLE.
- Address mapping:
  - QPSK: I address = b0 ? 1 : 0; Q address = b1 ? 1 : 0.
  - 16-QAM I from (b0, b2): 00→2, 01→4, 10→3, 11→5.
  - 16-QAM Q from (b1, b3) with the same mapping.
  - BPSK: I = Q = b0 ? 1 : 0. On odd symbol index the symbol is rotated by j: I address = b0 ? 0 : 1 and Q unchanged, giving (−a, +a)(1−2b).
- The symbol index parity resets to even on every i_start.
- Addresses are 0 when no symbol is being formed.
- The block performs no arithmetic on ROM data. The sign is selected by address only.

## Timing
- Reset values:
  - o_bit_ready 0, o_sym_valid 0, o_sym_i/o_sym_q 0, o_done 0, o_err 0.
  - o_rom_addr_1/o_rom_addr_2 0.
  - FSM state IDLE; all counters 0.
- Latency: o_sym_valid rises the cycle after the Qm-th bit is accepted.
- Ready rule in RUN: o_bit_ready = !o_sym_valid || i_sym_ready || (bit counter < Qm−1). Throughput is therefore one bit per cycle with no bubble while downstream is ready.
- Output register load:
  - Accept and new load in the same cycle: the new symbol replaces the old one and valid stays high.
  - Accept with no load: valid drops.
- Restart: i_start in RUN or DRAIN aborts the current block and restarts it. The collector, counters and parity are cleared and o_sym_valid is cleared in the same edge; o_done is not pulsed.
- i_bit_valid in IDLE or DRAIN is ignored.
- Symbol counter stops at i_num_sym; there is no wrap-around.

## Configuration
- PI2_BPSK_EN:
  - Defined: odd-index BPSK symbols are rotated as above.
  - Undefined: BPSK is plain, I = Q on every symbol, and the parity register is removed.

## Structure
- Package const_mapper_pkg holds:
  - enum mod_e (BPSK, QPSK, QAM16, RSVD);
  - localparams for ROM addresses ADDR_P_A, ADDR_N_A, ADDR_P_1, ADDR_N_1, ADDR_P_3, ADDR_N_3;
  - function qm_of(mod_e).
- One sub-module, const_bit_collector: holds the shift register and bit counter, and outputs the group plus a last-bit strobe.
- The ROM is instantiated beside this block in the parent, not inside it.

## Test plan
- QPSK, num_sym 2, bits 0,0,1,1 → addr pairs (0,0) then (1,1); symbols (+a,+a), (−a,−a); o_done one cycle after the second accept.
- 16-QAM, bits b0..b3 = 1,0,1,1 → addr (5,4); symbol (−3/√10, +3/√10).
- BPSK with PI2_BPSK_EN, bits 0,0 → (+a,+a) then (−a,+a). Without the macro → (+a,+a) twice.
- i_sym_ready held low with a symbol pending, QPSK → o_bit_ready drops after one further bit. Symbol held stable; no bit lost after release.
- i_start mid-16-QAM after 2 bits → collector cleared; the next 4 bits form symbol 0 with even parity; no o_done.
- i_mod = 11 → o_err = 1, o_bit_ready stays 0. i_num_sym = 0 → o_done pulse, no o_sym_valid. i_rst mid-RUN → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/const_mapper_pkg.sv
// Shared types, ROM address map and modulation helpers for the uplink constellation mapper.
// ROM holds signed constants; the sign of each symbol component is chosen purely by address.
package const_mapper_pkg;

  typedef enum logic [1:0] {
    BPSK  = 2'b00,
    QPSK  = 2'b01,
    QAM16 = 2'b10,
    RSVD  = 2'b11
  } mod_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  localparam logic [2:0] ADDR_P_A = 3'd0;  // +1/sqrt(2)
  localparam logic [2:0] ADDR_N_A = 3'd1;  // -1/sqrt(2)
  localparam logic [2:0] ADDR_P_1 = 3'd2;  // +1/sqrt(10)
  localparam logic [2:0] ADDR_N_1 = 3'd3;  // -1/sqrt(10)
  localparam logic [2:0] ADDR_P_3 = 3'd4;  // +3/sqrt(10)
  localparam logic [2:0] ADDR_N_3 = 3'd5;  // -3/sqrt(10)

  function automatic logic [2:0] qm_of(input mod_e m);
    case (m)
      BPSK:    return 3'd1;
      QPSK:    return 3'd2;
      QAM16:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // 16-QAM axis: first bit picks the sign, second bit picks the 1 or 3 amplitude.
  function automatic logic [2:0] qam_addr(input logic sgn, input logic mag);
    case ({sgn, mag})
      2'b00:   return ADDR_P_1;
      2'b01:   return ADDR_P_3;
      2'b10:   return ADDR_N_1;
      default: return ADDR_N_3;
    endcase
  endfunction

endpackage

// File: rtl/const_mapper_bit_collector.sv
// Gathers up to four serial bits (b0 first) and strobes o_last on the Qm-th accepted bit.
// o_group already contains the incoming bit so the group is usable in the cycle it completes.
module const_bit_collector (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_accept,
  input  logic       i_bit,
  input  logic [2:0] i_qm,
  output logic [3:0] o_group,
  output logic [1:0] o_cnt,
  output logic       o_last
);

  logic [3:0] bits_q, bits_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    o_group        = bits_q;
    o_group[cnt_q] = i_bit;
    o_last         = i_accept && ({1'b0, cnt_q} == i_qm - 3'd1);
    o_cnt          = cnt_q;
    bits_d         = bits_q;
    cnt_d          = cnt_q;
    if (i_clear) begin
      bits_d = '0;
      cnt_d  = '0;
    end else if (i_accept) begin
      if (o_last) begin
        bits_d = '0;
        cnt_d  = '0;
      end else begin
        bits_d[cnt_q] = i_bit;
        cnt_d         = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/const_mapper.sv
// Constellation mapper: serial bits -> ROM addresses -> registered I/Q symbol, one cycle after the Qm-th bit.
// Bits stall only when a full symbol is pending downstream; PI2_BPSK_EN enables pi/2 rotation of odd BPSK symbols.
module const_mapper #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int NSYM_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mod,
  input  logic [NSYM_WIDTH-1:0] i_num_sym,
  input  logic                  i_bit,
  input  logic                  i_bit_valid,
  output logic                  o_bit_ready,
  output logic [ADDR_WIDTH-1:0] o_rom_addr_1,
  output logic [ADDR_WIDTH-1:0] o_rom_addr_2,
  input  logic [DATA_WIDTH-1:0] i_rom_data_1,
  input  logic [DATA_WIDTH-1:0] i_rom_data_2,
  output logic [DATA_WIDTH-1:0] o_sym_i,
  output logic [DATA_WIDTH-1:0] o_sym_q,
  output logic                  o_sym_valid,
  input  logic                  i_sym_ready,
  output logic                  o_done,
  output logic                  o_err
);
  import const_mapper_pkg::*;

  state_e                state_q, state_d;
  mod_e                  mod_q, mod_d;
  logic [NSYM_WIDTH-1:0] num_q, num_d;
  logic [NSYM_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
  logic [DATA_WIDTH-1:0] sym_re_q, sym_re_d;
  logic [DATA_WIDTH-1:0] sym_im_q, sym_im_d;
  logic                  vld_q, vld_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef PI2_BPSK_EN
  logic                  par_q, par_d;
`endif

  logic [2:0] qm;
  logic [3:0] grp;
  logic [1:0] coll_cnt;
  logic       load;
  logic       bit_rdy;
  logic       bit_acc;
  logic       sym_acc;
  logic [2:0] addr_i, addr_q;

  assign qm      = qm_of(mod_q);
  // A partially collected group can keep filling even while a symbol waits downstream.
  assign bit_rdy = (state_q == ST_RUN) && !i_start &&
                   (!vld_q || i_sym_ready || ({1'b0, coll_cnt} < qm - 3'd1));
  assign bit_acc = bit_rdy && i_bit_valid;
  assign sym_acc = vld_q && i_sym_ready;

  const_bit_collector u_collector (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_start),
    .i_accept (bit_acc),
    .i_bit    (i_bit),
    .i_qm     (qm),
    .o_group  (grp),
    .o_cnt    (coll_cnt),
    .o_last   (load)
  );

  always_comb begin
    addr_i = '0;
    addr_q = '0;
    if (load) begin
      case (mod_q)
        BPSK: begin
          addr_i = grp[0] ? ADDR_N_A : ADDR_P_A;
          addr_q = grp[0] ? ADDR_N_A : ADDR_P_A;
`ifdef PI2_BPSK_EN
          if (par_q) addr_i = grp[0] ? ADDR_P_A : ADDR_N_A;
`endif
        end
        QPSK: begin
          addr_i = grp[0] ? ADDR_N_A : ADDR_P_A;
          addr_q = grp[1] ? ADDR_N_A : ADDR_P_A;
        end
        QAM16: begin
          addr_i = qam_addr(grp[0], grp[2]);
          addr_q = qam_addr(grp[1], grp[3]);
        end
        default: begin
          addr_i = '0;
          addr_q = '0;
        end
      endcase
    end
  end

  assign o_rom_addr_1 = ADDR_WIDTH'(addr_i);
  assign o_rom_addr_2 = ADDR_WIDTH'(addr_q);

  always_comb begin
    state_d   = state_q;
    mod_d     = mod_q;
    num_d     = num_q;
    sym_cnt_d = sym_cnt_q;
    sym_re_d  = sym_re_q;
    sym_im_d  = sym_im_q;
    vld_d     = vld_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef PI2_BPSK_EN
    par_d     = par_q;
`endif
    if (i_start) begin
      mod_d     = mod_e'(i_mod);
      num_d     = i_num_sym;
      sym_cnt_d = '0;
      vld_d     = 1'b0;
`ifdef PI2_BPSK_EN
      par_d     = 1'b0;
`endif
      if (mod_e'(i_mod) == RSVD) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        err_d = 1'b0;
        if (i_num_sym == '0) begin
          state_d = ST_IDLE;
          done_d  = (state_q == ST_IDLE);
        end else begin
          state_d = ST_RUN;
        end
      end
    end else begin
      if (sym_acc) vld_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (load) begin
            sym_re_d  = i_rom_data_1;
            sym_im_d  = i_rom_data_2;
            vld_d     = 1'b1;
            sym_cnt_d = sym_cnt_q + NSYM_WIDTH'(1);
`ifdef PI2_BPSK_EN
            par_d     = !par_q;
`endif
            if (sym_cnt_q + NSYM_WIDTH'(1) == num_q) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (sym_acc) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      mod_q     <= BPSK;
      num_q     <= '0;
      sym_cnt_q <= '0;
      sym_re_q  <= '0;
      sym_im_q  <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PI2_BPSK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mod_q     <= mod_d;
      num_q     <= num_d;
      sym_cnt_q <= sym_cnt_d;
      sym_re_q  <= sym_re_d;
      sym_im_q  <= sym_im_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PI2_BPSK_EN
      par_q     <= par_d;
`endif
    end
  end

  assign o_bit_ready = bit_rdy;
  assign o_sym_i     = sym_re_q;
  assign o_sym_q     = sym_im_q;
  assign o_sym_valid = vld_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
